mem_bank_linebuf: RTL
=====================

Name: mem_bank_linebuf

Overview:
- Streaming line buffer for the convolution datapath: KERNEL_SIZE parallel 1W/1R memory banks, each one image line deep.
- Accepts one pixel per cycle in raster order with a valid/ready handshake.
- Emits a KERNEL_SIZE-tall pixel column (oldest line to newest) once enough lines are buffered.
- Feeds the KERNEL_SIZE x KERNEL_SIZE window shifter ahead of the MAC array.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMAGE_SIZE, 16, pixels per image line (bank depth)
KERNEL_SIZE, 3, number of banks / output column height; legal range 2 or more
ADDR_SIZE, 4, column address width; must satisfy 2^ADDR_SIZE >= IMAGE_SIZE

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
frame_start  input  1  synchronous frame restart; clears counters and state, not RAM contents
in_valid  input  1  in_data valid
in_data  input  DATA_WIDTH  pixel, raster order
in_ready  output  1  pixel accepted when in_valid && in_ready
out_valid  output  1  out_col valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_col  output  KERNEL_SIZE*DATA_WIDTH  slice k = bits[k*DATA_WIDTH +: DATA_WIDTH]; slice 0 = oldest line, slice KERNEL_SIZE-1 = newest pixel
out_col_idx  output  ADDR_SIZE  column index of out_col
busy  output  1  high while state is STREAM

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_col=0, out_col_idx=0, col=0, wr_bank=0, lines_filled=0, state=FILL. RAM contents are not cleared.
- frame_start: same effect as reset. It has priority over rst-free traffic. in_ready=0 in any cycle where frame_start=1, so no pixel is accepted that cycle.
- in_ready = !frame_start && (!out_valid || out_ready). This is combinational; there is no skid buffer.
- Accept (fire):
  - write bank[wr_bank][col] <= in_data.
  - col increments. At col==IMAGE_SIZE-1 it wraps to 0, wr_bank advances modulo KERNEL_SIZE, and lines_filled increments, saturating at KERNEL_SIZE-1.
- States:
  - FILL: lines_filled < KERNEL_SIZE-1. Pixels are written and no output is produced.
  - STREAM: entered on the same fire that completes line KERNEL_SIZE-2 (lines_filled reaches KERNEL_SIZE-1). Left only on rst or frame_start.
- Output (fire while in STREAM), 1-cycle latency:
  - slice k (k = 0..KERNEL_SIZE-2) = bank[(wr_bank+1+k) mod KERNEL_SIZE][col], read with registered synchronous read.
  - slice KERNEL_SIZE-1 = registered in_data.
  - out_col_idx = col.
  - out_valid = 1.
- Hold: out_valid stays 1 and out_col/out_col_idx stay stable until out_ready=1. Bank read enables are asserted only on fire, so the read registers hold during a stall.
- No read/write collision is possible, because the bank being written is never read in the same cycle.
- If out_valid && out_ready && !fire: out_valid <= 0 next cycle. If out_valid && out_ready && fire: new data loads back-to-back with no bubble.
- Frame end: the buffer does not detect frame end. Upstream drives frame_start before each new frame.

Optional Feature:
- Macro: MEM_BANK_LINEBUF_ZERO_PAD_EN.
- Defined:
  - FILL is skipped; state is STREAM from reset, so output starts from the first pixel.
  - Slice k is forced to 0 when it refers to an unwritten line, i.e. when k < KERNEL_SIZE-1-lines_filled. This provides top zero-padding.
- Undefined: behaviour exactly as above. out_valid does not assert before KERNEL_SIZE-1 full lines have been written.

Test Plan:
All tests use IMAGE_SIZE=4, KERNEL_SIZE=3, DATA_WIDTH=8, out_ready=1, and pixels 1..16 driven continuously.
1. Fill and first output:
   - Pixels 1..8 -> out_valid stays 0.
   - Pixel 9 -> next cycle out_valid=1, out_col slices {0:1, 1:5, 2:9}, out_col_idx=0.
2. Bank rotation:
   - Pixel 13 -> out_col {0:5, 1:9, 2:13}, idx 0.
   - Pixel 16 -> {0:8, 1:12, 2:16}, idx 3.
3. Backpressure:
   - Drop out_ready for 3 cycles after pixel 10 is output -> in_ready=0, out_col held at {2,6,10}.
   - Raise out_ready -> pixel 11 yields {3,7,11} with no loss or duplicate.
4. frame_start mid-line:
   - Assert after 10 pixels -> out_valid=0 next cycle, busy=0.
   - The following 8 pixels produce no output; the 9th gives idx 0.
5. rst during stall with out_valid=1:
   - out_valid=0, out_col=0, busy=0 next cycle; refill is required as in test 1.
6. With MEM_BANK_LINEBUF_ZERO_PAD_EN:
   - Pixel 1 -> {0:0, 1:0, 2:1}.
   - Pixel 5 -> {0:0, 1:1, 2:5}.
   - Pixel 9 -> {1, 5, 9}.

Source files
------------

// File: rtl/mem_bank_linebuf.sv
// Streaming line buffer: KERNEL_SIZE one-line banks emitting a pixel column per accepted pixel.
// Optional top zero-padding (no FILL phase) when MEM_BANK_LINEBUF_ZERO_PAD_EN is defined.
module mem_bank_linebuf #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMAGE_SIZE  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_SIZE   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] out_col,
    output logic [ADDR_SIZE-1:0]              out_col_idx,
    output logic                              busy
);

    localparam int BANK_W = $clog2(KERNEL_SIZE);

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;
`ifdef MEM_BANK_LINEBUF_ZERO_PAD_EN
    localparam logic [0:0] INIT_STATE = STREAM;
`else
    localparam logic [0:0] INIT_STATE = FILL;
`endif

    localparam logic [ADDR_SIZE-1:0] COL_LAST  = ADDR_SIZE'(IMAGE_SIZE - 1);
    localparam logic [BANK_W-1:0]    BANK_LAST = BANK_W'(KERNEL_SIZE - 1);
    localparam logic [BANK_W-1:0]    LINES_MAX = BANK_W'(KERNEL_SIZE - 1);

    logic [DATA_WIDTH-1:0] bank_mem [KERNEL_SIZE][IMAGE_SIZE];

    logic [0:0]                        state_q, state_d;
    logic [ADDR_SIZE-1:0]              col_q, col_d;
    logic [BANK_W-1:0]                 wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0]                 lines_q, lines_d;
    logic                              out_valid_q, out_valid_d;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] out_col_q, out_col_d;
    logic [ADDR_SIZE-1:0]              out_idx_q, out_idx_d;

    logic                              fire_s;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] rd_col_s;

    // No skid buffer: stall upstream whenever the output register cannot be refilled.
    assign in_ready    = !frame_start && (!out_valid_q || out_ready);
    assign fire_s      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign out_col     = out_col_q;
    assign out_col_idx = out_idx_q;
    assign busy        = (state_q == STREAM);

    // Bank write: the bank being written is never among the banks read this cycle.
    always_ff @(posedge clk) begin
        if (fire_s && !rst) begin
            bank_mem[wr_bank_q][col_q] <= in_data;
        end
    end

    // Column assembly: slice k reads the bank k+1 lines after the write bank (oldest first).
    always_comb begin
        rd_col_s = '0;
        for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
            int sel;
            sel = int'(wr_bank_q) + 1 + k;
            sel = (sel >= KERNEL_SIZE) ? (sel - KERNEL_SIZE) : sel;
            rd_col_s[k*DATA_WIDTH +: DATA_WIDTH] = bank_mem[sel[BANK_W-1:0]][col_q];
`ifdef MEM_BANK_LINEBUF_ZERO_PAD_EN
            if (k < (KERNEL_SIZE - 1 - int'(lines_q))) begin
                rd_col_s[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else begin
                rd_col_s[k*DATA_WIDTH +: DATA_WIDTH] = bank_mem[sel[BANK_W-1:0]][col_q];
            end
`endif
        end
        rd_col_s[(KERNEL_SIZE-1)*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    // Next-state: position counters, fill tracking and the output register handshake.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        wr_bank_d   = wr_bank_q;
        lines_d     = lines_q;
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        out_idx_d   = out_idx_q;
        if (frame_start) begin
            state_d     = INIT_STATE;
            col_d       = '0;
            wr_bank_d   = '0;
            lines_d     = '0;
            out_valid_d = 1'b0;
            out_col_d   = '0;
            out_idx_d   = '0;
        end else begin
            if (fire_s) begin
                if (col_q == COL_LAST) begin
                    col_d     = '0;
                    wr_bank_d = (wr_bank_q == BANK_LAST) ? '0 : (wr_bank_q + 1'b1);
                    lines_d   = (lines_q == LINES_MAX) ? lines_q : (lines_q + 1'b1);
                    if (lines_d == LINES_MAX) begin
                        state_d = STREAM;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                col_d = col_q;
            end

            if (fire_s && (state_q == STREAM)) begin
                out_valid_d = 1'b1;
                out_col_d   = rd_col_s;
                out_idx_d   = col_q;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // State registers with synchronous reset; RAM contents are left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_STATE;
            col_q       <= '0;
            wr_bank_q   <= '0;
            lines_q     <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            wr_bank_q   <= wr_bank_d;
            lines_q     <= lines_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_idx_q   <= out_idx_d;
        end
    end

endmodule
